temp_f2c_converter: RTL

- Converts an 8-bit unsigned Fahrenheit value to a signed 8-bit Celsius value, C = (F − 32) × 5 / 9.
- Covers the Fahrenheit-to-Celsius direction of the temperature-conversion path. The Celsius-to-Fahrenheit direction is served by the lookup-ROM path.
- Computes arithmetically with a bit-serial restoring divider behind valid/ready handshakes on both sides.
- Sits between the switch/input capture logic and the seven-segment display driver.

---
 rtl/temp_f2c_converter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/temp_f2c_converter.sv
// temp_f2c_converter: 8-bit unsigned Fahrenheit to signed 8-bit Celsius,
// C = (F - 32) * 5 / 9, using a bit-serial restoring divider behind
// valid/ready handshakes. The result is also presented as sign + magnitude
// for the seven-segment display driver.
//
// state | meaning
// IDLE  | ready for a new Fahrenheit sample
// PREP  | form (F-32)*5, latch sign, build dividend, clear remainder
// DIV   | one restoring-division quotient bit per cycle, 12 cycles
// DONE  | result valid, held until out_ready
module temp_f2c_converter #(
    parameter int ROUND_NEAREST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_fahr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_celsius,
    output logic       out_neg,
    output logic [6:0] out_mag
);

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    // Adding half the divisor to 2*mag turns the truncating divide by 18
    // into round-to-nearest of mag/9.
    localparam logic [11:0] RND = (ROUND_NEAREST != 0) ? 12'd9 : 12'd0;

    state_t      state_q, state_d;
    logic [7:0]  fahr_q, fahr_d;
    logic        sign_q, sign_d;
    logic [11:0] dvd_q, dvd_d;
    logic [4:0]  rem_q, rem_d;
    // Quotient never exceeds 124, so before the final bit arrives it fits in 6 bits.
    logic [5:0]  quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  cel_q, cel_d;
    logic        neg_q, neg_d;
    logic [6:0]  mag_q, mag_d;

    logic [11:0] num_w;
    logic [11:0] abs_w;
    logic [5:0]  trial_w;
    logic        qbit_w;
    logic [4:0]  rem_next_w;
    logic [6:0]  q_fin_w;
    logic        neg_fin_w;

    // State register and datapath flops; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fahr_q  <= 8'd0;
            sign_q  <= 1'b0;
            dvd_q   <= 12'd0;
            rem_q   <= 5'd0;
            quo_q   <= 6'd0;
            cnt_q   <= 4'd0;
            cel_q   <= 8'd0;
            neg_q   <= 1'b0;
            mag_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            fahr_q  <= fahr_d;
            sign_q  <= sign_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            cel_q   <= cel_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = PREP;
            PREP: state_d = DIV;
            DIV:  if (cnt_q == 4'd0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Arithmetic: scaled difference, one restoring-divide step, final sign fix-up.
    always_comb begin
        // 12-bit wrap-around arithmetic; -160..1115 fits as signed 12-bit.
        num_w      = ({4'd0, fahr_q} - 12'd32) * 12'd5;
        abs_w      = num_w[11] ? (12'd0 - num_w) : num_w;
        trial_w    = {rem_q, dvd_q[11]};
        qbit_w     = (trial_w >= 6'd18);
        // trial - 18 is at most 17 whenever it is taken, so 5 bits suffice.
        rem_next_w = qbit_w ? (trial_w[4:0] - 5'd18) : trial_w[4:0];
        q_fin_w    = {quo_q, qbit_w};
        neg_fin_w  = sign_q & (q_fin_w != 7'd0);
    end

    // Datapath register updates per state.
    always_comb begin
        fahr_d = fahr_q;
        sign_d = sign_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        cel_d  = cel_q;
        neg_d  = neg_q;
        mag_d  = mag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) fahr_d = in_fahr;
            end
            PREP: begin
                sign_d = num_w[11];
                dvd_d  = (abs_w << 1) + RND;
                rem_d  = 5'd0;
                quo_d  = 6'd0;
                cnt_d  = 4'd11;
            end
            DIV: begin
                rem_d = rem_next_w;
                quo_d = {quo_q[4:0], qbit_w};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q - 4'd1;
                // Result registers load on the last divide step so they are
                // valid on entry to DONE and persist after the handshake.
                if (cnt_q == 4'd0) begin
                    mag_d = q_fin_w;
                    neg_d = neg_fin_w;
                    cel_d = neg_fin_w ? (8'd0 - {1'b0, q_fin_w}) : {1'b0, q_fin_w};
                end
            end
            default: ;
        endcase
    end

    assign out_celsius = cel_q;
    assign out_neg     = neg_q;
    assign out_mag     = mag_q;

endmodule
